// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI master blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam int SPI_MODE_0 = 0;
    localparam int SPI_MODE_3 = 1;

    function automatic logic sck_idle_level(input int mode);
        return (mode == SPI_MODE_3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clkgen.sv
// ============================================================================
// Module      : spi_clkgen
// Description : Half-period counter, sck level and edge strobes for SPI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clkgen #(
    parameter int CLK_DIV  = 3,
    parameter bit SCK_IDLE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic run_i,
    output logic sck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ph_q, ph_d;
    logic          sck_q, sck_d;
    logic          tick;

    // Strobes mark every half-period boundary; ph_q selects which edge it is.
    // When run_i is low the boundary parks sck at the idle level instead.
    always_comb begin
        tick  = en_i && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        ph_d  = ph_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = '0;
            ph_d  = 1'b0;
            sck_d = SCK_IDLE;
        end else if (tick) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
            sck_d = run_i ? ph_q : SCK_IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
            sck_q <= SCK_IDLE;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign rise_stb_o = tick & ph_q;
    assign fall_stb_o = tick & ~ph_q;

endmodule

`default_nettype wire

// File: rtl/spi_xfer.sv
// ============================================================================
// Module      : spi_xfer
// Description : SPI master transaction engine: CMD_W command bits then DATA_W
//               read or write data bits. Optional macro SPI_XFER_LOOPBACK_EN
//               adds the lpbk self-test port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer
    import spi_pkg::*;
#(
    parameter int CMD_W     = 8,
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 3,
    parameter int SPI_MODE3 = 0
) (
    input  logic              clk12MHz,
    input  logic              rst_n,
    input  logic              go,
    input  logic              rnw,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] recv_message,
    output logic              sck,
    output logic              csb,
    output logic              sdo,
    input  logic              sdi
`ifdef SPI_XFER_LOOPBACK_EN
    ,
    input  logic              lpbk
`endif
);

    localparam int            NBITS     = CMD_W + DATA_W;
    localparam int            BW        = $clog2(NBITS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_DATA0 = BW'(CMD_W);
    localparam bit            SCK_IDLE  = sck_idle_level(SPI_MODE3);

    spi_state_e        state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [NBITS-2:0]  tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] recv_q, recv_d;
    logic              rnw_q, rnw_d;
    logic              sdo_q, sdo_d;
    logic              csb_q, csb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              sck_w;
    logic              rise_stb;
    logic              fall_stb;
    logic              last_bit;
    logic              clk_en;
    logic              clk_run;
    logic              samp;
    logic [NBITS-1:0]  word;

`ifdef SPI_XFER_LOOPBACK_EN
    assign samp = lpbk ? sdo_q : sdi;
`else
    assign samp = sdi;
`endif

    assign last_bit = (bit_q == BIT_LAST);
    assign clk_en   = (state_q != ST_IDLE);
    // The fall that ends the last bit parks sck at idle rather than driving it low.
    assign clk_run  = (state_q == ST_SETUP) ||
                      ((state_q == ST_SHIFT) && !(fall_stb && last_bit));
    assign word     = {cmd_in, rnw ? {DATA_W{1'b0}} : wr_data};

    spi_clkgen #(
        .CLK_DIV  (CLK_DIV),
        .SCK_IDLE (SCK_IDLE)
    ) u_clkgen (
        .clk_i      (clk12MHz),
        .rst_ni     (rst_n),
        .en_i       (clk_en),
        .run_i      (clk_run),
        .sck_o      (sck_w),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go)                   state_d = ST_SETUP;
            ST_SETUP: if (fall_stb)             state_d = ST_SHIFT;
            ST_SHIFT: if (fall_stb && last_bit) state_d = ST_HOLD;
            ST_HOLD:  if (rise_stb)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csb_d  = csb_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sdo_d  = sdo_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        bit_d  = bit_q;
        rnw_d  = rnw_q;
        recv_d = recv_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    csb_d  = 1'b0;
                    busy_d = 1'b1;
                    rnw_d  = rnw;
                    sdo_d  = word[NBITS-1];
                    tx_d   = word[NBITS-2:0];
                    bit_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (rise_stb && rnw_q && (bit_q >= BIT_DATA0)) begin
                    rx_d = DATA_W'({rx_q, samp});
                end
                if (fall_stb) begin
                    if (last_bit) begin
                        sdo_d = 1'b0;
                    end else begin
                        sdo_d = tx_q[NBITS-2];
                        tx_d  = tx_q << 1;
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (rise_stb) begin
                    csb_d  = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    if (rnw_q) begin
                        recv_d = rx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            csb_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sdo_q  <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            bit_q  <= '0;
            rnw_q  <= 1'b0;
            recv_q <= '0;
        end else begin
            csb_q  <= csb_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sdo_q  <= sdo_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            bit_q  <= bit_d;
            rnw_q  <= rnw_d;
            recv_q <= recv_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign recv_message = recv_q;
    assign sck          = sck_w;
    assign csb          = csb_q;
    assign sdo          = sdo_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer.sv
// ============================================================================
// Module      : tb_spi_xfer
// Description : Directed self-checking bench for spi_xfer (default instance
//               in mode 0, second instance with CLK_DIV=1 in mode 3).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_xfer;

    localparam int CMD_W  = 8;
    localparam int DATA_W = 16;
    localparam int NBITS  = CMD_W + DATA_W;

    logic        clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    logic        rst_n;
    logic        go, rnw, sel;
    logic [7:0]  cmd;
    logic [15:0] wr;
    logic [15:0] pat;
    logic        go_a, go_b;

    logic        busy_a, done_a, sck_a, csb_a, sdo_a, sdi_a;
    logic [15:0] recv_a;
    logic        busy_b, done_b, sck_b, csb_b, sdo_b;
    logic [15:0] recv_b;
    logic        m_busy, m_done, m_sck, m_csb, m_sdo;

`ifdef SPI_XFER_LOOPBACK_EN
    logic        lpbk_a;
`endif

    int          n_checks, n_errors;
    int          cyc, rises, unstable, gaps, extra;
    logic [23:0] stream;
    int          rcnt;

    assign go_a   = go & ~sel;
    assign go_b   = go & sel;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_sck  = sel ? sck_b  : sck_a;
    assign m_csb  = sel ? csb_b  : csb_a;
    assign m_sdo  = sel ? sdo_b  : sdo_a;

    spi_xfer u_dut_a (
        .clk12MHz     (clk12MHz),
        .rst_n        (rst_n),
        .go           (go_a),
        .rnw          (rnw),
        .cmd_in       (cmd),
        .wr_data      (wr),
        .busy         (busy_a),
        .done         (done_a),
        .recv_message (recv_a),
        .sck          (sck_a),
        .csb          (csb_a),
        .sdo          (sdo_a),
        .sdi          (sdi_a)
`ifdef SPI_XFER_LOOPBACK_EN
        ,
        .lpbk         (lpbk_a)
`endif
    );

    spi_xfer #(
        .CLK_DIV   (1),
        .SPI_MODE3 (1)
    ) u_dut_b (
        .clk12MHz     (clk12MHz),
        .rst_n        (rst_n),
        .go           (go_b),
        .rnw          (rnw),
        .cmd_in       (cmd),
        .wr_data      (wr),
        .busy         (busy_b),
        .done         (done_b),
        .recv_message (recv_b),
        .sck          (sck_b),
        .csb          (csb_b),
        .sdo          (sdo_b),
        .sdi          (1'b1)
`ifdef SPI_XFER_LOOPBACK_EN
        ,
        .lpbk         (1'b0)
`endif
    );

    // Slave model: present the next data bit right after each sck rise.
    initial begin
        rcnt  = 0;
        sdi_a = 1'b0;
    end
    always @(posedge sck_a or posedge csb_a) begin
        if (csb_a) rcnt = 0;
        else       rcnt = rcnt + 1;
        if (rcnt >= CMD_W && rcnt < NBITS) sdi_a = pat[DATA_W-1-(rcnt-CMD_W)];
        else                               sdi_a = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic s, input logic [7:0] c, input logic [15:0] w,
                         input logic r, input logic hold);
        @(posedge clk12MHz); #1;
        sel = s; cmd = c; wr = w; rnw = r; go = 1'b1;
        @(posedge clk12MHz); #1;
        if (!hold) go = 1'b0;
    endtask

    // Counts cycles from the go edge to done and captures sdo on every sck rise.
    task automatic watch(input int budget, input int glitch_at, output int ncyc,
                         output logic [23:0] strm, output int nrise,
                         output int nunst, output int ngap);
        logic prev_sck, prev_sdo;
        bit   seen;
        ncyc = -1; strm = '0; nrise = 0; nunst = 0; ngap = 0; seen = 1'b0;
        prev_sck = m_sck; prev_sdo = m_sdo;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk12MHz);
            if (glitch_at >= 0 && i == glitch_at) begin
                go = 1'b1; cmd = 8'h00; wr = 16'hFFFF; rnw = 1'b1;
            end else if (glitch_at >= 0 && i == glitch_at + 1) begin
                go = 1'b0;
            end
            if (m_sck && !prev_sck) begin
                nrise++;
                strm = {strm[22:0], m_sdo};
                if (m_sdo !== prev_sdo) nunst++;
            end
            if (m_done) begin
                seen = 1'b1;
                ncyc = i;
            end else if (!m_busy) begin
                ngap++;
            end
            prev_sck = m_sck; prev_sdo = m_sdo;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        go = 1'b0; rnw = 1'b0; sel = 1'b0; cmd = '0; wr = '0; pat = '0;
`ifdef SPI_XFER_LOOPBACK_EN
        lpbk_a = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk12MHz);
        #1;
        check("rst_csb_a",  32'(csb_a),  32'h1);
        check("rst_sck_a",  32'(sck_a),  32'h0);
        check("rst_sck_b",  32'(sck_b),  32'h1);
        check("rst_sdo_a",  32'(sdo_a),  32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_recv_a", 32'(recv_a), 32'h0);
        rst_n = 1'b1;

        // Read, defaults, mode 0
        pat = 16'hFF11;
        start(1'b0, 8'hFA, 16'h5555, 1'b1, 1'b0);
        watch(400, -1, cyc, stream, rises, unstable, gaps);
        check("rd_latency",   32'(cyc),      32'd150);
        check("rd_stream",    32'(stream),   32'hFA0000);
        check("rd_rises",     32'(rises),    32'd24);
        check("rd_unstable",  32'(unstable), 32'd0);
        check("rd_busy_gaps", 32'(gaps),     32'd0);
        check("rd_done_busy", 32'(m_busy),   32'h0);
        check("rd_done_csb",  32'(m_csb),    32'h1);
        check("rd_recv",      32'(recv_a),   32'hFF11);
        @(negedge clk12MHz);
        check("rd_done_pulse", 32'(m_done),  32'h0);

        // Write, CLK_DIV=1, mode 3
        start(1'b1, 8'h74, 16'h2700, 1'b0, 1'b0);
        check("wr_sck_idle",  32'(sck_b),    32'h1);
        watch(200, -1, cyc, stream, rises, unstable, gaps);
        check("wr_latency",   32'(cyc),      32'd50);
        check("wr_stream",    32'(stream),   32'h742700);
        check("wr_rises",     32'(rises),    32'd24);
        check("wr_unstable",  32'(unstable), 32'd0);
        check("wr_done_sck",  32'(sck_b),    32'h1);
        check("wr_recv",      32'(recv_b),   32'h0);

        // go pulsed while busy
        start(1'b0, 8'h3C, 16'h1234, 1'b0, 1'b0);
        watch(400, 60, cyc, stream, rises, unstable, gaps);
        check("gl_latency",   32'(cyc),      32'd150);
        check("gl_stream",    32'(stream),   32'h3C1234);
        check("gl_recv",      32'(recv_a),   32'hFF11);
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk12MHz);
            if (done_a) extra++;
        end
        check("gl_extra_done", 32'(extra),   32'd0);
        check("gl_idle_csb",  32'(csb_a),    32'h1);

        // Async reset during bit 10
        pat = 16'hA5C3;
        start(1'b0, 8'hFA, 16'h0000, 1'b1, 1'b0);
        repeat (65) @(posedge clk12MHz);
        #3;
        check("mid_csb_active", 32'(csb_a),  32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_csb",  32'(csb_a),    32'h1);
        check("mid_rst_sck",  32'(sck_a),    32'h0);
        check("mid_rst_busy", 32'(busy_a),   32'h0);
        check("mid_rst_sdo",  32'(sdo_a),    32'h0);
        check("mid_rst_recv", 32'(recv_a),   32'h0);
        @(posedge clk12MHz); #1;
        rst_n = 1'b1;
        start(1'b0, 8'h9B, 16'h0000, 1'b1, 1'b0);
        watch(400, -1, cyc, stream, rises, unstable, gaps);
        check("post_latency", 32'(cyc),      32'd150);
        check("post_stream",  32'(stream),   32'h9B0000);
        check("post_recv",    32'(recv_a),   32'hA5C3);

        // Back-to-back with go held high
        pat = 16'h0F0F;
        start(1'b0, 8'hC3, 16'h0000, 1'b1, 1'b1);
        watch(400, -1, cyc, stream, rises, unstable, gaps);
        check("b2b1_latency", 32'(cyc),      32'd150);
        check("b2b1_recv",    32'(recv_a),   32'h0F0F);
        check("b2b_gap_csb",  32'(csb_a),    32'h1);
        @(posedge clk12MHz); #1;
        go = 1'b0;
        check("b2b_csb_low",  32'(csb_a),    32'h0);
        check("b2b_busy",     32'(busy_a),   32'h1);
        pat = 16'h8001;
        watch(400, -1, cyc, stream, rises, unstable, gaps);
        check("b2b2_latency", 32'(cyc),      32'd150);
        check("b2b2_stream",  32'(stream),   32'hC30000);
        check("b2b2_recv",    32'(recv_a),   32'h8001);

`ifdef SPI_XFER_LOOPBACK_EN
        lpbk_a = 1'b1;
        pat = 16'hFFFF;
        start(1'b0, 8'h80, 16'h0000, 1'b1, 1'b0);
        watch(400, -1, cyc, stream, rises, unstable, gaps);
        check("lb_latency",   32'(cyc),      32'd150);
        check("lb_stream",    32'(stream),   32'h800000);
        check("lb_recv",      32'(recv_a),   32'h0000);
        lpbk_a = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_xfer.md
Name: spi_xfer

Overview:
- Parametrised SPI master transaction engine. Successor to the fixed 8-bit-command / 16-bit-read SPI message block.
- One transaction runs as: csb low, CMD_W command bits out MSB-first, then DATA_W data bits MSB-first, then csb high.
- Each transaction is either a read (samples sdi) or a write (drives wr_data).
- Used by the BMP280 sensor controller and any other SPI peripheral on the board. Runs from the 12 MHz system clock.

Parameters:
- CMD_W, 8: command/address phase width in bits (>=1).
- DATA_W, 16: data phase width in bits (>=1).
- CLK_DIV, 3: sck half-period in clk12MHz cycles (>=1). sck frequency = 12 MHz / (2*CLK_DIV).
- SPI_MODE3, 0: 0 = SPI mode 0 (sck idles low); 1 = mode 3 (sck idles high).

Ports:
- clk12MHz  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  start request; sampled only in IDLE.
- rnw  in  1  1 = read data phase, 0 = write data phase; latched with go.
- cmd_in  in  CMD_W  command word; latched with go.
- wr_data  in  DATA_W  write data; latched with go.
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle pulse at transaction end.
- recv_message  out  DATA_W  last read data; holds until the next read completes.
- sck  out  1  SPI clock.
- csb  out  1  chip select, active low.
- sdo  out  1  MOSI.
- sdi  in  1  MISO.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; csb=1; sck=SPI_MODE3; sdo=0; busy=0; done=0; recv_message=0.
  - Takes effect immediately, also mid-transaction. The partially shifted word is discarded.
- All outputs are registered.
- Timing uses a half-period counter (0..CLK_DIV-1) and a bit counter of width clog2(CMD_W+DATA_W+1).
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - go=1 at edge E: latch cmd_in, wr_data and rnw.
  - At E: csb=0, busy=1, sdo=cmd MSB, enter SETUP.
  - go while busy is ignored; no queueing.
- SETUP: lasts CLK_DIV cycles, sck at idle level. Then enter SHIFT.
- SHIFT: CMD_W+DATA_W bits; each bit is 2*CLK_DIV cycles.
  - First half: sck=0, sdo holds the current bit.
  - Second half: sck=1.
  - sdi is sampled on the clk edge where sck rises.
  - sdo advances to the next bit on the clk edge where sck falls, i.e. at the start of the next bit.
  - Command bits always go out on sdo.
  - Data phase, rnw=0: sdo shifts out wr_data MSB-first.
  - Data phase, rnw=1: sdo=0 and sdi is shifted into a DATA_W shift register.
- Mode 3: the idle level is 1. In SETUP, sck falls at the start of bit 0, so edge semantics match mode 0.
- HOLD:
  - After the last bit, sck returns to the idle level and the state lasts CLK_DIV cycles.
  - Then csb=1, busy=0, done=1 for one cycle, return to IDLE.
  - If rnw=1, recv_message loads the shift register in the same cycle done rises.
- Latency from the go edge to the done-high edge: CLK_DIV + 2*CLK_DIV*(CMD_W+DATA_W) + CLK_DIV cycles. With defaults: 3+144+3 = 150.
- Back-to-back: go high in the done cycle is accepted (state is IDLE in that cycle). csb then stays high for exactly that one cycle.
- sdi is used directly. The synchroniser is the top level's responsibility.

Optional Feature:
- Macro: SPI_XFER_LOOPBACK_EN.
- Defined:
  - Adds input port lpbk (1 bit).
  - When lpbk=1, the read path samples the internal sdo register instead of sdi, and sdo still drives the pin.
  - Used for board self-test.
- Undefined: no lpbk port; sdi is always sampled.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - the SPI mode constants.
- Sub-module spi_clkgen: half-period counter plus sck/edge-strobe generation. Outputs are the rise_stb and fall_stb one-cycle strobes and the sck level. Shared with future SPI blocks.
- Shift registers and the FSM stay in spi_xfer.

Test Plan:
- Read, defaults, mode 0: cmd_in=0xFA, rnw=1, sdi drives 0xFF11 MSB-first on sck rises -> sdo shows 11111010 over 8 bits, then 0. recv_message=0xFF11. done exactly 150 cycles after go. busy low with done.
- Write, CLK_DIV=1, SPI_MODE3=1: cmd_in=0x74, wr_data=0x2700, rnw=0 -> sck idles 1, 24 rising edges. sdo stream is 0x742700 MSB-first, stable across every rise. recv_message unchanged. done at cycle 1+48+1=50.
- go pulsed again while busy=1 -> ignored. Exactly one done; latched cmd unchanged.
- rst_n low mid-SHIFT (bit 10) -> csb=1, sck=idle, busy=0 in the same cycle (async). Next go runs a full clean transaction.
- Back-to-back: go held high -> second transaction starts in the done cycle. csb high for exactly 1 cycle between frames.
- With SPI_XFER_LOOPBACK_EN, lpbk=1, rnw=1, cmd 0x80, sdi=1 -> recv_message=0x0000 (sdo=0 during the read phase).
